// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU input sequencer and its button debouncers.
`timescale 1ns/1ps
package alu_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_A   = 2'd0,
    WAIT_B   = 2'd1,
    WAIT_OP  = 2'd2,
    SHOW_RES = 2'd3
  } seq_state_t;

  localparam int SYNC_STAGES = 2;

  // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises a raw push-button, debounces it and emits a one-cycle pulse on each accepted press.
`timescale 1ns/1ps
module button_debouncer
  import alu_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam int FW = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [FW-1:0]          r_flush;
  logic                   r_level;
  logic                   r_press;
  logic                   r_armed;

  logic w_sync;
  logic w_differ;
  logic w_flip;
  logic w_settled;

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_differ  = (w_sync != r_level);
  assign w_flip    = w_differ && (r_cnt == LAST);
  assign w_settled = (r_flush == FW'(SYNC_STAGES));

  // A press only counts once the button has been seen released after reset, so a
  // button held through reset never produces a spurious press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_flush <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};

      if (!w_settled) begin
        r_flush <= r_flush + FW'(1);
      end

      if (w_settled && !w_sync && !r_level) begin
        r_armed <= 1'b1;
      end

      r_press <= w_flip && w_sync && r_armed;

      if (!w_differ) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_cnt   <= '0;
        r_level <= w_sync;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign btn_level = r_level;
  assign btn_press = r_press;

endmodule

// File: rtl/alu_input_sequencer.sv
// Steps the operator through A -> B -> Op -> result on NEXT, restarts on CLEAR,
// and hands a synchronised copy of the switch bank to the ALU register stage.
`timescale 1ns/1ps
module alu_input_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_next,
  input  logic             btn_clear,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] data_in,
  output logic             load_A,
  output logic             load_B,
  output logic             load_Op,
  output logic             updateRes,
  output logic [1:0]       stage
);

  logic w_next_level;
  logic w_next_press;
  logic w_clear_level;
  logic w_clear_press;
  logic w_unused_levels;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_next),
    .btn_level (w_next_level),
    .btn_press (w_next_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_clear),
    .btn_level (w_clear_level),
    .btn_press (w_clear_press)
  );

  assign w_unused_levels = w_next_level ^ w_clear_level;

  logic [WIDTH-1:0] r_sw_sync [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sw_sync[i] <= '0;
      end
    end else begin
      r_sw_sync[0] <= sw_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sw_sync[i] <= r_sw_sync[i-1];
      end
    end
  end

  assign data_in = r_sw_sync[SYNC_STAGES-1];

  seq_state_t r_state;
  seq_state_t w_state_next;
  logic       r_pending;
  logic       w_pending_next;
  logic       r_load_a;
  logic       r_load_b;
  logic       r_load_op;
  logic       r_update_res;
  logic       w_load_a;
  logic       w_load_b;
  logic       w_load_op;
  logic       w_update_res;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= WAIT_A;
      r_pending    <= 1'b0;
      r_load_a     <= 1'b0;
      r_load_b     <= 1'b0;
      r_load_op    <= 1'b0;
      r_update_res <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pending    <= w_pending_next;
      r_load_a     <= w_load_a;
      r_load_b     <= w_load_b;
      r_load_op    <= w_load_op;
      r_update_res <= w_update_res;
    end
  end

  // r_pending marks the cycle load_Op is on the bus; updateRes follows one cycle
  // later unless CLEAR lands in that cycle.
  always_comb begin
    w_state_next   = r_state;
    w_pending_next = 1'b0;
    w_load_a       = 1'b0;
    w_load_b       = 1'b0;
    w_load_op      = 1'b0;
    w_update_res   = 1'b0;

    if (w_clear_press) begin
      w_state_next = WAIT_A;
    end else begin
      w_update_res = r_pending;
      if (w_next_press) begin
        case (r_state)
          WAIT_A: begin
            w_load_a     = 1'b1;
            w_state_next = WAIT_B;
          end
          WAIT_B: begin
            w_load_b     = 1'b1;
            w_state_next = WAIT_OP;
          end
          WAIT_OP: begin
            w_load_op      = 1'b1;
            w_pending_next = 1'b1;
            w_state_next   = SHOW_RES;
          end
          default: begin
            w_state_next = WAIT_A;
          end
        endcase
      end
    end
  end

  assign load_A    = r_load_a;
  assign load_B    = r_load_b;
  assign load_Op   = r_load_op;
  assign updateRes = r_update_res;
  assign stage     = r_state;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed and random stimulus for alu_input_sequencer, checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_alu_input_sequencer;

  localparam int W = 16;
  localparam int D = 4;
  localparam int S_A = 0, S_B = 1, S_OP = 2, S_RES = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         btn_next = 1'b0;
  logic         btn_clear = 1'b0;
  logic [W-1:0] sw_in = '0;
  logic [W-1:0] data_in;
  logic         load_A, load_B, load_Op, updateRes;
  logic [1:0]   stage;

  alu_input_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_next  (btn_next),
    .btn_clear (btn_clear),
    .sw_in     (sw_in),
    .data_in   (data_in),
    .load_A    (load_A),
    .load_B    (load_B),
    .load_Op   (load_Op),
    .updateRes (updateRes),
    .stage     (stage)
  );

  always #1 clk = ~clk;

  // Behavioural model: a button's level flips once the last D synchronised samples
  // all disagree with it; a rise is a press only if the button was seen released after reset.
  logic [D:0]   m_hist [2];
  bit           m_level [2];
  bit           m_armed [2];
  bit           m_press [2];
  int           m_edges;
  int           m_state;
  bit           m_pend;
  logic [W-1:0] m_sw_prev;
  logic [W-1:0] e_data;
  logic [1:0]   e_stage;
  bit           e_la, e_lb, e_lop, e_upd;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_hist[b] = '0; m_level[b] = 0; m_armed[b] = 0; m_press[b] = 0;
    end
    m_edges = 0; m_state = S_A; m_pend = 0; m_sw_prev = '0;
    e_data = '0; e_stage = '0; e_la = 0; e_lb = 0; e_lop = 0; e_upd = 0;
  endtask

  task automatic model_step();
    bit raw [2];
    bit nxt, clr;
    raw[0] = btn_next; raw[1] = btn_clear;
    nxt = m_press[0]; clr = m_press[1];
    e_la = 0; e_lb = 0; e_lop = 0; e_upd = 0;
    if (clr) begin
      m_state = S_A; m_pend = 0;
    end else begin
      e_upd = m_pend; m_pend = 0;
      if (nxt) begin
        case (m_state)
          S_A:  begin e_la = 1; m_state = S_B; end
          S_B:  begin e_lb = 1; m_state = S_OP; end
          S_OP: begin e_lop = 1; m_state = S_RES; m_pend = 1; end
          default: m_state = S_A;
        endcase
      end
    end
    e_stage = 2'(m_state);
    e_data = m_sw_prev;
    m_sw_prev = sw_in;
    m_edges++;
    for (int b = 0; b < 2; b++) begin
      bit all_differ;
      all_differ = (m_hist[b][D:1] == {D{~m_level[b]}});
      m_press[b] = 0;
      if (all_differ) begin
        m_press[b] = !m_level[b] && m_armed[b];
        m_level[b] = ~m_level[b];
      end else if (m_edges >= 3 && m_hist[b][1] == 1'b0 && !m_level[b]) begin
        m_armed[b] = 1;
      end
      m_hist[b] = {m_hist[b][D-1:0], raw[b]};
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  int checks = 0, passed = 0, failed = 0;
  int cyc = 0, c0 = 0;
  int n_la, n_lb, n_lop, n_upd, c_la, c_lb, c_lop, c_upd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_la = 0; n_lb = 0; n_lop = 0; n_upd = 0;
    c_la = -1; c_lb = -1; c_lop = -1; c_upd = -1;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      check("cycle", {10'd0, data_in, stage, load_A, load_B, load_Op, updateRes},
                     {10'd0, e_data, e_stage, e_la, e_lb, e_lop, e_upd});
      if (load_A)    begin n_la++;  c_la  = cyc; end
      if (load_B)    begin n_lb++;  c_lb  = cyc; end
      if (load_Op)   begin n_lop++; c_lop = cyc; end
      if (updateRes) begin n_upd++; c_upd = cyc; end
    end
  endtask

  task automatic press_next(input int hold);
    btn_next = 1'b1;
    c0 = cyc;
    tick(hold);
    btn_next = 1'b0;
    tick(10);
  endtask

  initial begin
    clear_counts();
    // 1: reset with both buttons held
    btn_next = 1'b1; btn_clear = 1'b1; sw_in = 16'h1234;
    tick(3);
    check("t1_outputs_in_reset", {data_in, stage, load_A, load_B, load_Op, updateRes}, 0);
    reset = 1'b1;
    tick(20);
    check("t1_no_press_held", n_la + n_lb + n_lop + n_upd, 0);
    btn_next = 1'b0; btn_clear = 1'b0;
    tick(10);
    check("t1_no_press_release", n_la + n_lb + n_lop + n_upd, 0);

    // 2: full sequence of clean presses
    sw_in = 16'h00A5;
    tick(4);
    clear_counts(); press_next(10);
    check("t2_loadA_count", n_la, 1);
    check("t2_loadA_latency", c_la - c0, 7);
    clear_counts(); press_next(10);
    check("t2_loadB_count", n_lb, 1);
    check("t2_loadB_latency", c_lb - c0, 7);
    clear_counts(); press_next(10);
    check("t2_loadOp_count", n_lop, 1);
    check("t2_loadOp_latency", c_lop - c0, 7);
    check("t2_updateRes_count", n_upd, 1);
    check("t2_updateRes_latency", c_upd - c0, 8);
    clear_counts(); press_next(10);
    check("t2_show_res_no_strobe", n_la + n_lb + n_lop + n_upd, 0);
    check("t2_stage_back", stage, 0);
    check("t2_data_in", data_in, 16'h00A5);

    // 3: bouncing NEXT, then held
    clear_counts();
    btn_next = 1'b1; tick(2);
    btn_next = 1'b0; tick(2);
    btn_next = 1'b1; tick(2);
    btn_next = 1'b0; tick(2);
    btn_next = 1'b1; c0 = cyc;
    tick(20);
    check("t3_single_loadA", n_la, 1);
    check("t3_loadA_latency", c_la - c0, 7);
    check("t3_stage", stage, 1);
    btn_next = 1'b0; tick(10);

    // 4: CLEAR and NEXT together in WAIT_B
    clear_counts();
    btn_next = 1'b1; btn_clear = 1'b1;
    tick(15);
    check("t4_no_strobe", n_la + n_lb + n_lop + n_upd, 0);
    check("t4_stage", stage, 0);
    btn_next = 1'b0; btn_clear = 1'b0; tick(10);

    // 5: CLEAR press lands in the load_Op cycle
    press_next(8); press_next(8);
    clear_counts();
    btn_next = 1'b1; tick(1);
    btn_clear = 1'b1; tick(15);
    check("t5_loadOp_count", n_lop, 1);
    check("t5_updateRes_cancelled", n_upd, 0);
    check("t5_stage", stage, 0);
    btn_next = 1'b0; btn_clear = 1'b0; tick(10);

    // 6: reset in WAIT_OP mid-debounce
    press_next(8); press_next(8);
    check("t6_stage_wait_op", stage, 2);
    btn_next = 1'b1; tick(2);
    reset = 1'b0;
    #0.5;
    check("t6_async_reset", {data_in, stage, load_A, load_B, load_Op, updateRes}, 0);
    btn_next = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(5);
    clear_counts(); press_next(8);
    check("t6_loadA_after_reset", n_la, 1);
    check("t6_loadA_latency", c_la - c0, 7);
    check("t6_other_strobes", n_lb + n_lop + n_upd, 0);

    // random section
    for (int it = 0; it < 250; it++) begin
      sw_in = 16'($urandom);
      btn_next = ($urandom_range(0, 2) != 0);
      btn_clear = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b0; tick(1); reset = 1'b1;
      end
      tick($urandom_range(1, 9));
    end
    btn_next = 1'b0; btn_clear = 1'b0;
    tick(20);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
